// File: rtl/rdmx_xmit_fe_q.sv
// Write-only AXI front end: queues AW requests, streams W beats straight to
// AXIS_DATA, builds a per-packet metadata word and returns in-order B responses.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; a source holds valid and its payload until that edge, and
// ready may depend combinationally on valid.
module rdmx_xmit_fe_q #(
  parameter int DW        = 512,
  parameter int AW        = 64,
  parameter int UW        = 32,
  parameter int IDW       = 4,
  parameter int AWQ_DEPTH = 8,
  parameter int MAX_BYTES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     S_AXI_AWADDR,
  input  logic [UW-1:0]     S_AXI_AWUSER,
  input  logic [IDW-1:0]    S_AXI_AWID,
  input  logic [7:0]        S_AXI_AWLEN,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [DW-1:0]     S_AXI_WDATA,
  input  logic [DW/8-1:0]   S_AXI_WSTRB,
  input  logic              S_AXI_WLAST,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [IDW-1:0]    S_AXI_BID,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  output logic [AW-1:0]     AXIS_META_TDATA,
  output logic [UW+16:0]    AXIS_META_TUSER,
  output logic              AXIS_META_TVALID,
  input  logic              AXIS_META_TREADY,
  output logic [DW-1:0]     AXIS_DATA_TDATA,
  output logic              AXIS_DATA_TLAST,
  output logic              AXIS_DATA_TVALID,
  input  logic              AXIS_DATA_TREADY
);

  localparam int SW = DW / 8;
  localparam int PW = (AWQ_DEPTH > 1) ? $clog2(AWQ_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = AW + UW + IDW + 8;
  localparam int BW = IDW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(AWQ_DEPTH);
  localparam logic [15:0]   MAX_C   = 16'(MAX_BYTES);

  // AW queue: {addr, user, id, len}
  logic [EW-1:0]  awq_mem_q [AWQ_DEPTH];
  logic [PW-1:0]  awq_wr_ptr_q, awq_wr_ptr_d, awq_rd_ptr_q, awq_rd_ptr_d;
  logic [CW-1:0]  awq_cnt_q, awq_cnt_d;
  // B queue: {id, resp}
  logic [BW-1:0]  bq_mem_q [AWQ_DEPTH];
  logic [PW-1:0]  bq_wr_ptr_q, bq_wr_ptr_d, bq_rd_ptr_q, bq_rd_ptr_d;
  logic [CW-1:0]  bq_cnt_q, bq_cnt_d;
  // packet accumulators
  logic [15:0]    acc_q, acc_d;
  logic [8:0]     beat_cnt_q, beat_cnt_d;
  // metadata register
  logic           meta_valid_q, meta_valid_d;
  logic [AW-1:0]  meta_addr_q, meta_addr_d;
  logic [UW+16:0] meta_tuser_q, meta_tuser_d;

  logic [EW-1:0]  head;
  logic [AW-1:0]  head_addr;
  logic [UW-1:0]  head_user;
  logic [IDW-1:0] head_id;
  logic [7:0]     head_len;
  logic           awq_full, awq_empty, bq_full, gate;
  logic           aw_push, w_hs, last_hs, b_pop, pkt_err;
  logic [15:0]    beat_bytes, plen;
  logic [BW-1:0]  b_head;

  assign head      = awq_mem_q[awq_rd_ptr_q];
  assign head_addr = head[EW-1 -: AW];
  assign head_user = head[UW+IDW+7 -: UW];
  assign head_id   = head[IDW+7 -: IDW];
  assign head_len  = head[7:0];

  assign awq_full  = (awq_cnt_q == DEPTH_C);
  assign awq_empty = (awq_cnt_q == '0);
  assign bq_full   = (bq_cnt_q == DEPTH_C);

  // A last beat may only pass when its metadata and B response have room.
  assign gate = !awq_empty && (!S_AXI_WLAST || (!meta_valid_q && !bq_full));

  assign S_AXI_AWREADY    = !reset && !awq_full;
  assign S_AXI_WREADY     = AXIS_DATA_TREADY && gate;
  assign AXIS_DATA_TVALID = S_AXI_WVALID && gate;
  assign AXIS_DATA_TDATA  = S_AXI_WDATA;
  assign AXIS_DATA_TLAST  = S_AXI_WLAST;

  assign aw_push = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign last_hs = w_hs && S_AXI_WLAST;
  assign b_pop   = S_AXI_BVALID && S_AXI_BREADY;

  assign b_head       = bq_mem_q[bq_rd_ptr_q];
  assign S_AXI_BVALID = (bq_cnt_q != '0);
  assign S_AXI_BID    = b_head[BW-1 -: IDW];
  assign S_AXI_BRESP  = b_head[1:0];

  assign AXIS_META_TVALID = meta_valid_q;
  assign AXIS_META_TDATA  = meta_addr_q;
  assign AXIS_META_TUSER  = meta_tuser_q;

  // Byte count of the current beat is the number of set strobes.
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < SW; i++) beat_bytes = beat_bytes + {15'd0, S_AXI_WSTRB[i]};
  end

  assign plen    = acc_q + beat_bytes;
  assign pkt_err = ((beat_cnt_q + 9'd1) != ({1'b0, head_len} + 9'd1)) || (plen > MAX_C);

  // Next-state for queue pointers, accumulators and the metadata register.
  always_comb begin
    awq_wr_ptr_d = awq_wr_ptr_q;
    awq_rd_ptr_d = awq_rd_ptr_q;
    awq_cnt_d    = awq_cnt_q;
    bq_wr_ptr_d  = bq_wr_ptr_q;
    bq_rd_ptr_d  = bq_rd_ptr_q;
    bq_cnt_d     = bq_cnt_q;
    acc_d        = acc_q;
    beat_cnt_d   = beat_cnt_q;
    meta_valid_d = meta_valid_q;
    meta_addr_d  = meta_addr_q;
    meta_tuser_d = meta_tuser_q;

    if (aw_push) awq_wr_ptr_d = awq_wr_ptr_q + PW'(1);
    if (last_hs) awq_rd_ptr_d = awq_rd_ptr_q + PW'(1);
    case ({aw_push, last_hs})
      2'b10:   awq_cnt_d = awq_cnt_q + CW'(1);
      2'b01:   awq_cnt_d = awq_cnt_q - CW'(1);
      default: awq_cnt_d = awq_cnt_q;
    endcase

    if (last_hs) bq_wr_ptr_d = bq_wr_ptr_q + PW'(1);
    if (b_pop)   bq_rd_ptr_d = bq_rd_ptr_q + PW'(1);
    case ({last_hs, b_pop})
      2'b10:   bq_cnt_d = bq_cnt_q + CW'(1);
      2'b01:   bq_cnt_d = bq_cnt_q - CW'(1);
      default: bq_cnt_d = bq_cnt_q;
    endcase

    if (w_hs) begin
      if (S_AXI_WLAST) begin
        acc_d      = '0;
        beat_cnt_d = '0;
      end else begin
        acc_d      = plen;
        beat_cnt_d = beat_cnt_q + 9'd1;
      end
    end

    if (meta_valid_q && AXIS_META_TREADY) meta_valid_d = 1'b0;
    if (last_hs) begin
      meta_valid_d = 1'b1;
      meta_addr_d  = head_addr;
      meta_tuser_d = {pkt_err, plen, head_user};
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      awq_wr_ptr_q <= '0;
      awq_rd_ptr_q <= '0;
      awq_cnt_q    <= '0;
      bq_wr_ptr_q  <= '0;
      bq_rd_ptr_q  <= '0;
      bq_cnt_q     <= '0;
      acc_q        <= '0;
      beat_cnt_q   <= '0;
      meta_valid_q <= 1'b0;
      meta_addr_q  <= '0;
      meta_tuser_q <= '0;
    end else begin
      awq_wr_ptr_q <= awq_wr_ptr_d;
      awq_rd_ptr_q <= awq_rd_ptr_d;
      awq_cnt_q    <= awq_cnt_d;
      bq_wr_ptr_q  <= bq_wr_ptr_d;
      bq_rd_ptr_q  <= bq_rd_ptr_d;
      bq_cnt_q     <= bq_cnt_d;
      acc_q        <= acc_d;
      beat_cnt_q   <= beat_cnt_d;
      meta_valid_q <= meta_valid_d;
      meta_addr_q  <= meta_addr_d;
      meta_tuser_q <= meta_tuser_d;
    end
  end

  // Queue storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (aw_push) awq_mem_q[awq_wr_ptr_q] <= {S_AXI_AWADDR, S_AXI_AWUSER, S_AXI_AWID, S_AXI_AWLEN};
    if (last_hs) bq_mem_q[bq_wr_ptr_q]   <= {head_id, (pkt_err ? 2'b10 : 2'b00)};
  end

endmodule
